ladybird_fetch: RTL
===================

# ladybird_fetch

Instruction fetch stage that sits directly upstream of the MMU instruction port. It generates sequential fetch addresses on the MMU `pc`/`pc_valid`/`pc_ready` handshake and accepts returned `inst`/`inst_pc` words into a small instruction queue. It presents those words in order to the decode stage. Redirects from execute (branch, jump, trap) restart fetch at a new address and silently discard every response still in flight from the old path.

## Interface
- `XLEN`, 32: address and instruction width.
- `RESET_VECTOR`, 32'h0000_0000: first fetch address after reset.
- `QUEUE_DEPTH`, 4: instruction queue entries; power of two, 2..16.

- `clk`  in  1  clock; all state updates on the rising edge.
- `nrst`  in  1  reset; one clock, asynchronous, active-low.
- `pc`  out  XLEN  fetch address to MMU.
- `pc_valid`  out  1  fetch request valid.
- `pc_ready`  in  1  MMU accepts the request.
- `inst`  in  XLEN  returned instruction word.
- `inst_pc`  in  XLEN  address of the returned word.
- `inst_valid`  in  1  response valid.
- `inst_ready`  out  1  response accepted; constant 1 outside reset.
- `redirect_valid`  in  1  restart fetch this cycle.
- `redirect_pc`  in  XLEN  new fetch address; bits [1:0] ignored and forced to 0.
- `o_inst`  out  XLEN  instruction to decode.
- `o_pc`  out  XLEN  address of `o_inst`.
- `o_valid`  out  1  `o_inst` valid.
- `o_ready`  in  1  decode consumes the word.

## Operation
- State:
  - `fetch_pc_q`: next address to request.
  - `inflight_q`: requests issued and not yet answered; 0..QUEUE_DEPTH.
  - `discard_q`: in-flight responses to drop; always ≤ `inflight_q`.
  - Circular queue: storage, head pointer, tail pointer, and `count_q`.
- Issue:
  - `pc = fetch_pc_q`.
  - `pc_valid = ~redirect_valid & (count_q + inflight_q < QUEUE_DEPTH)`. Queue space is reserved per request, so a response can never find the queue full.
  - On `pc_valid & pc_ready`: `fetch_pc_q += 4`, modulo 2^XLEN (wrap-around allowed), and `inflight` increments.
- Response (`inst_valid & inst_ready`): `inflight` decrements.
  - If `discard_q != 0`: the word is dropped and `discard` decrements.
  - Otherwise `{inst_pc, inst}` is pushed at the tail.
- Drain:
  - `o_valid = (count_q != 0) & ~redirect_valid`.
  - `o_inst`/`o_pc` come from the head entry.
  - On `o_valid & o_ready` the head pops.
  - A push and a pop in the same cycle leave `count` unchanged.
- Redirect (`redirect_valid`), highest priority:
  - `fetch_pc_q <= {redirect_pc[XLEN-1:2], 2'b00}`.
  - The queue is cleared: count = 0 and head = tail.
  - No issue occurs this cycle.
  - A response arriving this cycle is dropped.
  - `discard_d = inflight_q - resp`, where `resp` = response accepted this cycle.
  - `inflight_d = inflight_q - resp`.
  - Back-to-back redirects: the last one wins, and the discard count is recomputed each cycle by the same rule.
- Invariant: every word delivered on `o_*` was fetched after the most recent redirect, and words are delivered in fetch order.

## Timing
- Reset values:
  - `pc = RESET_VECTOR`.
  - `pc_valid = 0` while `nrst` is low, then 1 in the first cycle after release, provided `redirect_valid = 0`.
  - `inst_ready = 0` during reset.
  - `o_valid = 0`, `o_inst = 0`, `o_pc = 0`.
  - `inflight = discard = count = 0`.
- Reset asserted mid-operation clears all state immediately. In-flight MMU responses that arrive after release are accepted and counted only if `inflight_q != 0`. Because `inflight_q` is 0 after reset, the system must reset the MMU together with this block.
- Latency: a response accepted in cycle N gives `o_valid = 1` in cycle N+1 (see Configuration for bypass).
- Redirect in cycle N: the first request to the new `pc` is issued no earlier than N+1.
- Full queue: `pc_valid` stays low until `count_q + inflight_q < QUEUE_DEPTH`. A pop in cycle N enables issue in N+1.
- `pc` and `pc_valid` are stable while `pc_valid & ~pc_ready`, unless `redirect_valid` is asserted. A redirect may withdraw a pending request; the MMU only samples on handshake.

## Configuration
- `LADYBIRD_FETCH_BYPASS_EN`:
  - Defined: when `count_q == 0`, a non-discarded response drives `o_inst`/`o_pc`/`o_valid` combinationally in the same cycle. If `o_ready` is also high, the word is consumed and not pushed. If `o_ready` is low, the word is pushed.
  - Undefined: all words pass through the queue, with the 1-cycle latency above. `o_*` are driven only from registers and `redirect_valid`.

## Test plan
- Reset release with `pc_ready` = 1 and MMU latency 1: requests 0x0, 0x4, 0x8 are issued in consecutive accept cycles. `o_pc` delivers 0x0, 0x4, 0x8 in order with matching `o_inst`.
- `o_ready = 0`, QUEUE_DEPTH = 4: exactly 4 requests are issued, then `pc_valid` stays 0. Raising `o_ready` for one cycle gives one pop, and a new request (0x10) is issued the next cycle.
- Two requests in flight, then a redirect to 0x100 (`redirect_pc` = 0x103): both old responses are dropped, the next `pc` is 0x100, and the first `o_pc` is 0x100.
- Redirect in the same cycle as a response and `o_valid` = 1: the response is dropped, `o_valid` = 0 that cycle, and the queue is empty the next cycle.
- `RESET_VECTOR` = 0xFFFF_FFFC: the second request is to 0x0000_0000 and both words are delivered in order.
- Bypass build, empty queue, `o_ready` = 1: `o_valid` is high in the same cycle as `inst_valid` and `count` stays 0. Non-bypass build: `o_valid` rises one cycle later.

Source files
------------

// File: rtl/ladybird_fetch_if.sv
// Fetch-stage bus bundle: MMU request/response, execute redirect and decode handoff.
// The master modport is the fetch stage's view; slave is the surrounding pipeline/MMU.
interface ladybird_fetch_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] pc;
   logic            pc_valid;
   logic            pc_ready;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;
   logic            inst_valid;
   logic            inst_ready;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic [XLEN-1:0] o_inst;
   logic [XLEN-1:0] o_pc;
   logic            o_valid;
   logic            o_ready;

   modport master (
      output pc, pc_valid, inst_ready, o_inst, o_pc, o_valid,
      input  pc_ready, inst, inst_pc, inst_valid, redirect_valid, redirect_pc, o_ready
   );

   modport slave (
      input  pc, pc_valid, inst_ready, o_inst, o_pc, o_valid,
      output pc_ready, inst, inst_pc, inst_valid, redirect_valid, redirect_pc, o_ready
   );
endinterface

// File: rtl/ladybird_fetch.sv
// Instruction fetch: sequential MMU requests, in-order instruction queue, redirect with discard.
// Optional LADYBIRD_FETCH_BYPASS_EN: a response into an empty queue is presented to decode the same cycle.
module ladybird_fetch #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              QUEUE_DEPTH  = 4
) (
   input logic              clk,
   input logic              nrst,
   ladybird_fetch_if.master bus
);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(QUEUE_DEPTH);

   typedef logic [CW-1:0] cnt_t;
   typedef logic [PW-1:0] ptr_t;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   cnt_t            inflight_q, inflight_d;
   cnt_t            discard_q, discard_d;
   cnt_t            count_q, count_d;
   ptr_t            head_q, head_d;
   ptr_t            tail_q, tail_d;
   logic [XLEN-1:0] mem_inst_q [QUEUE_DEPTH];
   logic [XLEN-1:0] mem_pc_q   [QUEUE_DEPTH];

   logic            issue, resp, keep, push, pop, bypass, has_head;
   logic [CW:0]     occupancy;
   logic            unused_redirect_lsb;

   assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

   // Queue space is reserved per request, so a kept response always finds room.
   assign occupancy    = {1'b0, count_q} + {1'b0, inflight_q};
   assign has_head     = (count_q != '0);
   assign bus.pc       = fetch_pc_q;
   assign bus.pc_valid = nrst & ~bus.redirect_valid & (occupancy < DEPTH_C);
   assign bus.inst_ready = nrst;

   assign issue = bus.pc_valid & bus.pc_ready;
   assign resp  = bus.inst_valid & bus.inst_ready & (inflight_q != '0);
   assign keep  = resp & (discard_q == '0) & ~bus.redirect_valid;

`ifdef LADYBIRD_FETCH_BYPASS_EN
   assign bypass = keep & ~has_head;
`else
   assign bypass = 1'b0;
`endif

   assign bus.o_valid = (has_head | bypass) & ~bus.redirect_valid;
   assign bus.o_inst  = has_head ? mem_inst_q[head_q] : (bypass ? bus.inst    : '0);
   assign bus.o_pc    = has_head ? mem_pc_q[head_q]   : (bypass ? bus.inst_pc : '0);

   assign pop  = bus.o_valid & bus.o_ready & has_head;
   assign push = keep & ~(bypass & bus.o_ready);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      inflight_d = inflight_q;
      discard_d  = discard_q;
      count_d    = count_q;
      head_d     = head_q;
      tail_d     = tail_q;
      if (bus.redirect_valid) begin
         // Everything still outstanding belongs to the abandoned path.
         fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
         inflight_d = inflight_q - cnt_t'(resp);
         discard_d  = inflight_q - cnt_t'(resp);
         count_d    = '0;
         head_d     = tail_q;
      end else begin
         if (issue)
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         inflight_d = inflight_q + cnt_t'(issue) - cnt_t'(resp);
         if (resp && (discard_q != '0))
            discard_d = discard_q - cnt_t'(1);
         if (push)
            tail_d = tail_q + ptr_t'(1);
         if (pop)
            head_d = head_q + ptr_t'(1);
         count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         fetch_pc_q <= RESET_VECTOR;
         inflight_q <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // Storage needs no reset: outputs are gated by count_q.
   always_ff @(posedge clk) begin
      if (push && !bus.redirect_valid) begin
         mem_inst_q[tail_q] <= bus.inst;
         mem_pc_q[tail_q]   <= bus.inst_pc;
      end
   end
endmodule
